spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have no parameters; the frame is fixed at 10 rx bits and 8 tx bits.
REQ-002 clk  input  1  sole clock; all state SHALL change on posedge clk only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; high SHALL mean no frame in progress.
REQ-005 MOSI  input  1  serial data from master, MSB first, sampled on posedge clk.
REQ-006 MISO  output  1  serial read data to master, MSB first.
REQ-007 rx_data  output  10  assembled command word to RAM: [9:8] opcode, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by RAM.
REQ-010 tx_valid  input  1  qualifies tx_data; sampled only while waiting for read data.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD on the edge where SS_n=0; MOSI SHALL be ignored on that edge.
REQ-013 In CHK_CMD, the sampled MOSI SHALL become rx bit 9; MOSI=0 -> WRITE; MOSI=1 with rd_addr_flag=0 -> READ_ADD; MOSI=1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 In WRITE/READ_ADD/READ_DATA, the next 9 edges SHALL shift MOSI into bits 8..0; a 4-bit counter SHALL track received bits.
REQ-015 On the edge sampling bit 0, rx_data SHALL load the full 10-bit word and rx_valid SHALL go high for exactly one cycle; opcode bits SHALL be forwarded unmodified regardless of state.
REQ-016 rx_data SHALL hold its value until the next completed frame.
REQ-017 WRITE and READ_ADD SHALL remain in state, idle on MOSI, after rx_valid until SS_n=1.
REQ-018 rd_addr_flag SHALL set when a READ_ADD frame issues rx_valid and clear when a READ_DATA frame issues rx_valid.
REQ-019 In READ_DATA after rx_valid, the block SHALL wait for tx_valid=1; on that edge tx_data SHALL load an 8-bit shift register.
REQ-020 Starting the cycle after capture, MISO SHALL present tx_data[7], [6], ... [0], one bit per cycle for 8 cycles, then return to 0.
REQ-021 tx_valid SHALL be ignored in every other state/phase; a second tx_valid during shifting SHALL be ignored.
REQ-022 MISO SHALL be 0 whenever not shifting read data.
REQ-023 SS_n=1 in any non-IDLE state SHALL force IDLE on that edge, clear counters and shift registers, and suppress rx_valid for a partial word; rd_addr_flag SHALL be unchanged by an abort.
REQ-024 Completed frame state then SS_n=1 -> IDLE; SS_n held low in IDLE on the same edge SHALL go directly to CHK_CMD.

Reset
REQ-025 With rst_n=0 at posedge clk: state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_flag=0, counters and shift registers 0; reset SHALL override SS_n and abort any frame.

Verification
REQ-026 Write address: SS_n low, MOSI 0,0,1,0,1,0,0,1,0,1 -> rx_data=10'h0A5, rx_valid high 1 cycle on 11th edge after SS_n fall; MISO stays 0.
REQ-027 Write data: MOSI 0,1,0x3C bits -> rx_data=10'h13C, one rx_valid pulse; rd_addr_flag remains 0.
REQ-028 Read address then read data: frame 10'h2A5 -> state READ_ADD, flag=1; next frame 10'h300 -> state READ_DATA, rx_valid, flag=0; drive tx_data=8'hC3, tx_valid=1 -> MISO 1,1,0,0,0,0,1,1 over next 8 cycles.
REQ-029 Abort: SS_n high after 5 bits -> IDLE next edge, no rx_valid, rx_data unchanged; following full frame received correctly.
REQ-030 Reset mid-read-shift (after 3 MISO bits) -> MISO=0, IDLE, flag=0; next 1-first frame enters READ_ADD.
REQ-031 tx_valid pulsed during WRITE frame -> no MISO activity, rx_data unaffected.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: 10-bit command frames in on MOSI,
// 8-bit read data out on MISO after a read-data command.
module spi_slave (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       MOSI,
   output logic       MISO,
   output logic [9:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid
);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

   state_t     r_state, w_next;
   logic [3:0] r_bit_cnt;
   logic [9:0] r_rx_sh;
   logic [9:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_rd_addr_flag;
   logic [6:0] r_tx_sh;
   logic [2:0] r_tx_left;
   logic       r_tx_busy;
   logic       r_tx_done;
   logic       r_miso;

   logic       w_abort;
   logic       w_rx_shift;
   logic       w_rx_last;
   logic       w_tx_load;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!SS_n) w_next = CHK_CMD;
         CHK_CMD: begin
            if (SS_n)                w_next = IDLE;
            else if (!MOSI)          w_next = WRITE;
            else if (r_rd_addr_flag) w_next = READ_DATA;
            else                     w_next = READ_ADD;
         end
         default: if (SS_n) w_next = IDLE;
      endcase
   end

   // Bit count of 9 marks a fully received word; read data is captured once per frame.
   always_comb begin
      w_abort    = (r_state != IDLE) && SS_n;
      w_rx_shift = (r_state == WRITE || r_state == READ_ADD || r_state == READ_DATA) &&
                   (r_bit_cnt != 4'd9);
      w_rx_last  = w_rx_shift && (r_bit_cnt == 4'd8);
      w_tx_load  = (r_state == READ_DATA) && (r_bit_cnt == 4'd9) && !r_tx_done && tx_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bit_cnt      <= '0;
         r_rx_sh        <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rd_addr_flag <= 1'b0;
         r_tx_sh        <= '0;
         r_tx_left      <= '0;
         r_tx_busy      <= 1'b0;
         r_tx_done      <= 1'b0;
         r_miso         <= 1'b0;
      end else if (w_abort) begin
         r_bit_cnt  <= '0;
         r_rx_sh    <= '0;
         r_rx_valid <= 1'b0;
         r_tx_sh    <= '0;
         r_tx_left  <= '0;
         r_tx_busy  <= 1'b0;
         r_tx_done  <= 1'b0;
         r_miso     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (r_state == CHK_CMD) begin
            r_rx_sh   <= {9'd0, MOSI};
            r_bit_cnt <= '0;
         end
         if (w_rx_shift) begin
            r_rx_sh   <= {r_rx_sh[8:0], MOSI};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
         if (w_rx_last) begin
            r_rx_data  <= {r_rx_sh[8:0], MOSI};
            r_rx_valid <= 1'b1;
            if (r_state == READ_ADD)       r_rd_addr_flag <= 1'b1;
            else if (r_state == READ_DATA) r_rd_addr_flag <= 1'b0;
         end
         // MSB goes straight to MISO on capture; the other 7 bits follow from r_tx_sh.
         if (w_tx_load) begin
            r_miso    <= tx_data[7];
            r_tx_sh   <= tx_data[6:0];
            r_tx_left <= 3'd7;
            r_tx_busy <= 1'b1;
            r_tx_done <= 1'b1;
         end else if (r_tx_busy) begin
            if (r_tx_left != 3'd0) begin
               r_miso    <= r_tx_sh[6];
               r_tx_sh   <= {r_tx_sh[5:0], 1'b0};
               r_tx_left <= r_tx_left - 3'd1;
            end else begin
               r_miso    <= 1'b0;
               r_tx_busy <= 1'b0;
            end
         end
      end
   end

   assign MISO     = r_miso;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: frame-position reference model plus directed
// and randomized frames, aborts and resets.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst_n, SS_n, MOSI, tx_valid;
   logic [7:0] tx_data;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   spi_slave dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
   );

   always #5 clk = ~clk;

   // Reference model: k = number of edges seen with SS_n low since the frame began.
   // Edge 1 is the idle edge, edge 2 carries bit 9, edges 3..11 carry bits 8..0.
   int         k = 0;
   bit         m_flag = 0;
   int         m_kind = 0;  // 0 write, 1 read address, 2 read data
   logic [9:0] m_word = '0;
   logic [9:0] m_rx = '0;
   bit         m_valid = 0, m_miso = 0, m_await = 0;
   bit         m_q[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         k = 0; m_flag = 0; m_rx = '0; m_valid = 0; m_await = 0; m_miso = 0;
         m_q.delete();
      end else if (SS_n) begin
         k = 0; m_valid = 0; m_await = 0; m_miso = 0;
         m_q.delete();
      end else begin
         k++;
         m_valid = 0;
         if (m_await && tx_valid) begin
            for (int i = 7; i >= 0; i--) m_q.push_back(tx_data[i]);
            m_await = 0;
         end
         m_miso = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
         if (k == 2) begin
            m_word = {9'd0, MOSI};
            m_kind = MOSI ? (m_flag ? 2 : 1) : 0;
         end else if (k >= 3 && k <= 11) begin
            m_word = {m_word[8:0], MOSI};
            if (k == 11) begin
               m_rx = m_word;
               m_valid = 1;
               if (m_kind == 1) m_flag = 1;
               if (m_kind == 2) begin m_flag = 0; m_await = 1; end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rx_valid", {9'd0, rx_valid}, {9'd0, m_valid});
         chk("rx_data", rx_data, m_rx);
         chk("MISO", {9'd0, MISO}, {9'd0, m_miso});
      end
   end

   task automatic cyc(input logic ss, input logic mo, input logic tv, input logic [7:0] td);
      @(negedge clk);
      SS_n = ss; MOSI = mo; tx_valid = tv; tx_data = td;
   endtask

   // Idle edge (random MOSI, must be ignored) followed by the 10 frame bits.
   task automatic frame(input logic [9:0] w, input logic tv);
      cyc(1'b0, 1'($urandom_range(0, 1)), tv, 8'hFF);
      for (int i = 9; i >= 0; i--) cyc(1'b0, w[i], tv, 8'hFF);
   endtask

   task automatic frame_chk(input string nm, input logic [9:0] w);
      frame(w, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk({nm, "_valid"}, {9'd0, rx_valid}, 10'd1);
      chk({nm, "_data"}, rx_data, w);
   endtask

   logic [7:0] got;

   initial begin
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_rx_data", rx_data, 10'h000);
      chk("rst_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk("rst_miso", {9'd0, MISO}, 10'd0);
      chk_en = 1;
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Write address, write data (with tx_valid noise during the frame)
      frame_chk("wr_addr", 10'h0A5);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      frame(10'h13C, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      chk("wr_data_valid", {9'd0, rx_valid}, 10'd1);
      chk("wr_data", rx_data, 10'h13C);
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("wr_miso_quiet", {9'd0, MISO}, 10'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Read address then read data, second tx_valid mid-shift ignored
      frame_chk("rd_addr", 10'h2A5);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      frame_chk("rd_data", 10'h300);
      cyc(1'b0, 1'b0, 1'b1, 8'hC3);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, (i == 2), 8'h00);
         got[7-i] = MISO;
      end
      chk("rd_miso_bits", {2'b00, got}, 10'h0C3);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("rd_miso_after", {9'd0, MISO}, 10'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Abort after 5 bits, then a clean frame
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 9; i >= 5; i--) cyc(1'b0, (i % 2 == 0), 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("abort_valid", {9'd0, rx_valid}, 10'd0);
      chk("abort_data", rx_data, 10'h300);
      frame_chk("post_abort", 10'h0F0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Reset in the middle of read data shifting
      frame_chk("rst_rd_addr", 10'h2A5);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      frame_chk("rst_rd_data", 10'h3C0);
      cyc(1'b0, 1'b0, 1'b1, 8'hA5);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_mid_miso", {9'd0, MISO}, 10'd0);
      chk("rst_mid_data", rx_data, 10'h000);
      rst_n = 1'b1;
      frame_chk("after_rst", 10'h2A5);
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      chk("after_rst_miso", {9'd0, MISO}, 10'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Randomized frames with aborts, tx_valid noise and occasional resets
      for (int n = 0; n < 300; n++) begin
         logic [9:0] w;
         int         ab, tail;
         bit         aborted;
         w = 10'($urandom);
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
         aborted = 0;
         cyc(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 20), 8'($urandom));
         for (int i = 9; i >= 0; i--) begin
            if (i == ab) begin aborted = 1; break; end
            cyc(1'b0, w[i], ($urandom_range(0, 99) < 20), 8'($urandom));
         end
         if (!aborted) begin
            tail = $urandom_range(0, 14);
            for (int t = 0; t < tail; t++) begin
               cyc(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30), 8'($urandom));
               rst_n = ($urandom_range(0, 99) != 0);
            end
         end
         cyc(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30), 8'($urandom));
         rst_n = 1'b1;
         if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, 1'b0, 8'h00);
      end

      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
